// File: rtl/sd_spi_router_pkg.sv
// sd_spi_router_pkg: shared constants and the counter-width helper used by the
// SD-SPI router and its activity timers.
package sd_spi_router_pkg;

    // Select value that routes the core's SPI master to the physical card.
    localparam int SEL_PHY = 0;

    // Bits needed to hold any value 0..n. The router derives its select width
    // from this as cnt_w(NUM_VSD), which is $clog2(NUM_VSD+1).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sd_spi_router_act_timer.sv
// sd_act_timer: retriggerable activity stretcher. A kick restarts the count
// from zero, and the output stays high until the count saturates at HOLD.
module sd_act_timer
    import sd_spi_router_pkg::*;
#(
    parameter int HOLD = 1000000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic kick,
    output logic act
);

    localparam int CW = cnt_w(HOLD);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    logic [CW-1:0] r_count;

    // Up-counter: reset parks it at HOLD (idle), a kick restarts it at zero.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= HOLD_C;
        end else if (kick) begin
            r_count <= '0;
        end else if (r_count < HOLD_C) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign act = (r_count < HOLD_C);

endmodule

// File: rtl/sd_spi_router.sv
// sd_spi_router: routes the core's SPI master to the physical SD card or one
// of NUM_VSD virtual slots, stretches a core reset on every mount event, and
// drives per-target activity LEDs.
// Optional macro SDMUX_SEL_HOLD_EN: a mount event only updates a pending
// select, which is applied on the first cycle the SPI bus is idle.
module sd_spi_router
    import sd_spi_router_pkg::*;
#(
    parameter int NUM_VSD  = 2,
    parameter int RST_HOLD = 10000000,
    parameter int ACT_HOLD = 1000000,
    localparam int SEL_W   = cnt_w(NUM_VSD)
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_VSD-1:0] img_mounted,
    input  logic [NUM_VSD-1:0] img_nonempty,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               spi_cs_n,
    output logic               spi_miso,
    output logic               phy_sck,
    output logic               phy_mosi,
    output logic               phy_cs_n,
    input  logic               phy_miso,
    output logic [NUM_VSD-1:0] vsd_ss_n,
    input  logic [NUM_VSD-1:0] vsd_miso,
    output logic [SEL_W-1:0]   sel,
    output logic               reset_img,
    output logic               act_phy,
    output logic               act_vsd
);

    localparam int RCW = cnt_w(RST_HOLD);
    localparam logic [RCW-1:0] RST_HOLD_C = RCW'(RST_HOLD);
    localparam int MISO_W = 1 << SEL_W;

    logic [SEL_W-1:0]  r_sel;
    logic [RCW-1:0]    r_rst_cnt;
    logic              r_mosi_hist;
    logic              r_miso_hist;
    logic [SEL_W-1:0]  w_base_sel;
    logic [SEL_W-1:0]  w_next_sel;
    logic              w_any_mount;
    logic              w_phy_active;
    logic [MISO_W-1:0] w_miso_vec;
    logic              w_toggle;
    logic              w_kick_phy;
    logic              w_kick_vsd;

    assign w_any_mount  = |img_mounted;
    assign w_phy_active = (r_sel == SEL_W'(SEL_PHY));

    // Physical card only sees the bus while it is the selected target; its
    // clock and data are parked low whenever its chip select is inactive.
    always_comb begin
        phy_cs_n = spi_cs_n | ~w_phy_active;
        phy_sck  = spi_sck  & ~phy_cs_n;
        phy_mosi = spi_mosi & ~phy_cs_n;
    end

    // Each virtual slot gets its own select, active only when it is targeted.
    always_comb begin
        vsd_ss_n = '1;
        for (int k = 0; k < NUM_VSD; k++) begin
            vsd_ss_n[k] = spi_cs_n | (r_sel != SEL_W'(k + 1));
        end
    end

    // MISO mux: padding the vector to a power of two keeps the select index
    // in range for every legal sel value.
    always_comb begin
        w_miso_vec            = '0;
        w_miso_vec[NUM_VSD:0] = {vsd_miso, phy_miso};
        spi_miso              = w_miso_vec[r_sel];
    end

    // Mount resolution: slots are walked from highest to lowest so the lowest
    // pulsed slot has the final say. An empty image only deselects its own slot.
    always_comb begin
        w_next_sel = w_base_sel;
        for (int k = NUM_VSD - 1; k >= 0; k--) begin
            if (img_mounted[k]) begin
                if (img_nonempty[k]) begin
                    w_next_sel = SEL_W'(k + 1);
                end else if (w_base_sel == SEL_W'(k + 1)) begin
                    w_next_sel = SEL_W'(SEL_PHY);
                end
            end
        end
    end

`ifdef SDMUX_SEL_HOLD_EN
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_pend_valid;

    assign w_base_sel = r_pend_valid ? r_pend_sel : r_sel;

    // Deferred select: a mount parks its result until the bus is idle so an
    // in-flight transfer is never cut over to another card.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sel        <= SEL_W'(SEL_PHY);
            r_pend_sel   <= SEL_W'(SEL_PHY);
            r_pend_valid <= 1'b0;
        end else if (w_any_mount) begin
            if (spi_cs_n) begin
                r_sel        <= w_next_sel;
                r_pend_valid <= 1'b0;
            end else begin
                r_pend_sel   <= w_next_sel;
                r_pend_valid <= 1'b1;
            end
        end else if (r_pend_valid && spi_cs_n) begin
            r_sel        <= r_pend_sel;
            r_pend_valid <= 1'b0;
        end
    end
`else
    assign w_base_sel = r_sel;

    // Immediate select: a mount retargets the bus on the next cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sel <= SEL_W'(SEL_PHY);
        end else if (w_any_mount) begin
            r_sel <= w_next_sel;
        end
    end
`endif

    assign sel = r_sel;

    // Reset stretcher: any mount pulse reloads the count, so overlapping
    // pulses extend the core reset instead of restarting a fresh pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_cnt <= '0;
        end else if (w_any_mount) begin
            r_rst_cnt <= RST_HOLD_C;
        end else if (r_rst_cnt != '0) begin
            r_rst_cnt <= r_rst_cnt - 1'b1;
        end
    end

    assign reset_img = (r_rst_cnt != '0);

    // Data history for activity detection: one register each for MOSI and MISO.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mosi_hist <= 1'b0;
            r_miso_hist <= 1'b0;
        end else begin
            r_mosi_hist <= spi_mosi;
            r_miso_hist <= spi_miso;
        end
    end

    // A data toggle restarts the LED timer of whichever card is targeted now.
    always_comb begin
        w_toggle   = (spi_mosi != r_mosi_hist) | (spi_miso != r_miso_hist);
        w_kick_phy = w_toggle &  w_phy_active;
        w_kick_vsd = w_toggle & ~w_phy_active;
    end

    sd_act_timer #(.HOLD(ACT_HOLD)) u_act_phy (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .kick    (w_kick_phy),
        .act     (act_phy)
    );

    sd_act_timer #(.HOLD(ACT_HOLD)) u_act_vsd (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .kick    (w_kick_vsd),
        .act     (act_vsd)
    );

endmodule

// File: tb/tb_sd_spi_router.sv
// tb_sd_spi_router: directed self-checking bench for sd_spi_router with
// NUM_VSD = 2, RST_HOLD = 16, ACT_HOLD = 8.
`timescale 1ns/1ps
module tb_sd_spi_router;

    localparam int NUM_VSD  = 2;
    localparam int RST_HOLD = 16;
    localparam int ACT_HOLD = 8;

    logic       clk_sys;
    logic       reset_n;
    logic [1:0] img_mounted;
    logic [1:0] img_nonempty;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic       phy_sck;
    logic       phy_mosi;
    logic       phy_cs_n;
    logic       phy_miso;
    logic [1:0] vsd_ss_n;
    logic [1:0] vsd_miso;
    logic [1:0] sel;
    logic       reset_img;
    logic       act_phy;
    logic       act_vsd;

    int errors = 0;
    int checks = 0;

    sd_spi_router #(
        .NUM_VSD  (NUM_VSD),
        .RST_HOLD (RST_HOLD),
        .ACT_HOLD (ACT_HOLD)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_nonempty (img_nonempty),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .spi_miso     (spi_miso),
        .phy_sck      (phy_sck),
        .phy_mosi     (phy_mosi),
        .phy_cs_n     (phy_cs_n),
        .phy_miso     (phy_miso),
        .vsd_ss_n     (vsd_ss_n),
        .vsd_miso     (vsd_miso),
        .sel          (sel),
        .reset_img    (reset_img),
        .act_phy      (act_phy),
        .act_vsd      (act_vsd)
    );

    // 100 MHz system clock
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance one cycle and settle just after the active edge
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Drive a one-cycle mount pulse
    task automatic applyStimulus(input logic [1:0] mounted, input logic [1:0] nonempty);
        img_mounted  = mounted;
        img_nonempty = nonempty;
        tick();
        img_mounted  = 2'b00;
        img_nonempty = 2'b00;
    endtask

    // Reset values and idle routing
    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (reset_img !== 1'b0) begin errors++; $display("[TB] FAIL reset_img: got %0b expected 0", reset_img); end
        checks++; if ({act_phy, act_vsd} !== 2'b00) begin errors++; $display("[TB] FAIL reset_act: got %b expected 00", {act_phy, act_vsd}); end
        checks++; if (vsd_ss_n !== 2'b11) begin errors++; $display("[TB] FAIL reset_vsd_ss_n: got %b expected 11", vsd_ss_n); end
        checks++; if (phy_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_phy_cs_n: got %0b expected 1", phy_cs_n); end
        reset_n = 1'b1;
        tick();
    endtask

    // Physical card default routing and activity stretch
    task automatic test_phy_default();
        int hi;
        spi_cs_n = 1'b0;
        spi_sck  = 1'b1;
        #1;
        checks++; if (phy_sck !== 1'b1) begin errors++; $display("[TB] FAIL phy_sck_follow_hi: got %0b expected 1", phy_sck); end
        spi_sck = 1'b0;
        #1;
        checks++; if (phy_sck !== 1'b0) begin errors++; $display("[TB] FAIL phy_sck_follow_lo: got %0b expected 0", phy_sck); end
        checks++; if (vsd_ss_n !== 2'b11) begin errors++; $display("[TB] FAIL phy_vsd_ss_n: got %b expected 11", vsd_ss_n); end
        phy_miso = 1'b1;
        #1;
        checks++; if (spi_miso !== 1'b1) begin errors++; $display("[TB] FAIL phy_miso_route: got %0b expected 1", spi_miso); end
        phy_miso = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        checks++; if (act_phy !== 1'b0) begin errors++; $display("[TB] FAIL act_phy_idle: got %0b expected 0", act_phy); end
        spi_mosi = 1'b1;
        #1;
        checks++; if (phy_mosi !== 1'b1) begin errors++; $display("[TB] FAIL phy_mosi_follow: got %0b expected 1", phy_mosi); end
        checks++; if (act_phy !== 1'b0) begin errors++; $display("[TB] FAIL act_phy_before_edge: got %0b expected 0", act_phy); end
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (act_phy === 1'b1) hi++;
        end
        checks++; if (hi != ACT_HOLD) begin errors++; $display("[TB] FAIL act_phy_len: got %0d expected %0d", hi, ACT_HOLD); end
        checks++; if (act_vsd !== 1'b0) begin errors++; $display("[TB] FAIL act_vsd_quiet: got %0b expected 0", act_vsd); end
        checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL phy_sel: got %0d expected 0", sel); end
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick();
    endtask

    // Mount slot 1 non-empty: select, reset stretch and virtual routing
    task automatic test_mount_slot1();
        int hi;
        applyStimulus(2'b10, 2'b10);
        checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL mount1_sel: got %0d expected 2", sel); end
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (reset_img === 1'b1) hi++;
            if (i == 2) begin
                spi_cs_n = 1'b0;
                spi_sck  = 1'b1;
                vsd_miso = 2'b10;
                #1;
                if (vsd_ss_n !== 2'b01) begin errors++; $display("[TB] FAIL mount1_vsd_ss_n: got %b expected 01", vsd_ss_n); end
                if (phy_sck !== 1'b0) begin errors++; $display("[TB] FAIL mount1_phy_sck: got %0b expected 0", phy_sck); end
                if (spi_miso !== 1'b1) begin errors++; $display("[TB] FAIL mount1_miso_hi: got %0b expected 1", spi_miso); end
                vsd_miso = 2'b01;
                #1;
                if (spi_miso !== 1'b0) begin errors++; $display("[TB] FAIL mount1_miso_lo: got %0b expected 0", spi_miso); end
                checks += 4;
                spi_cs_n = 1'b1;
                spi_sck  = 1'b0;
                vsd_miso = 2'b00;
            end
            tick();
        end
        checks++; if (hi != RST_HOLD) begin errors++; $display("[TB] FAIL mount1_reset_len: got %0d expected %0d", hi, RST_HOLD); end
    endtask

    // Simultaneous mounts (lowest slot wins) and a reloading second pulse
    task automatic test_back_to_back();
        int hi;
        applyStimulus(2'b11, 2'b11);
        checks++; if (sel !== 2'd1) begin errors++; $display("[TB] FAIL simul_sel: got %0d expected 1", sel); end
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            if (reset_img === 1'b1) hi++;
            if (i == 4) begin
                img_mounted  = 2'b11;
                img_nonempty = 2'b11;
            end
            tick();
            img_mounted  = 2'b00;
            img_nonempty = 2'b00;
        end
        checks++; if (hi != 21) begin errors++; $display("[TB] FAIL retrigger_reset_len: got %0d expected 21", hi); end
        checks++; if (sel !== 2'd1) begin errors++; $display("[TB] FAIL retrigger_sel: got %0d expected 1", sel); end
    endtask

    // Empty remounts of the active and of a non-active slot
    task automatic test_empty_mount();
        applyStimulus(2'b10, 2'b10);
        checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL empty_pre_sel: got %0d expected 2", sel); end
        applyStimulus(2'b10, 2'b00);
        checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL empty_active_sel: got %0d expected 0", sel); end
        applyStimulus(2'b10, 2'b10);
        for (int i = 0; i < 20; i++) tick();
        checks++; if (reset_img !== 1'b0) begin errors++; $display("[TB] FAIL empty_reset_idle: got %0b expected 0", reset_img); end
        applyStimulus(2'b01, 2'b00);
        checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL empty_other_sel: got %0d expected 2", sel); end
        checks++; if (reset_img !== 1'b1) begin errors++; $display("[TB] FAIL empty_other_reset: got %0b expected 1", reset_img); end
        applyStimulus(2'b10, 2'b00);
        checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL empty_back_sel: got %0d expected 0", sel); end
    endtask

    // Mount during an active transfer
    task automatic test_sel_hold();
        int bad;
        spi_cs_n = 1'b0;
        tick();
        applyStimulus(2'b10, 2'b10);
        bad = 0;
`ifdef SDMUX_SEL_HOLD_EN
        for (int i = 0; i < 10; i++) begin
            if (sel !== 2'd0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL hold_sel_busy: got %0d bad cycles expected 0", bad); end
        spi_cs_n = 1'b1;
        #1;
        checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL hold_sel_at_rise: got %0d expected 0", sel); end
        tick();
        checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL hold_sel_after_rise: got %0d expected 2", sel); end
`else
        for (int i = 0; i < 10; i++) begin
            if (sel !== 2'd2) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL nohold_sel_busy: got %0d bad cycles expected 0", bad); end
        spi_cs_n = 1'b1;
        tick();
        checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL nohold_sel_after: got %0d expected 2", sel); end
`endif
    endtask

    // Asynchronous reset in the middle of a reset pulse and LED activity
    task automatic test_async_reset();
        spi_mosi = 1'b1;
        tick();
        applyStimulus(2'b10, 2'b00);
        spi_mosi = 1'b0;
        tick();
        applyStimulus(2'b01, 2'b01);
        checks++; if ({sel, reset_img, act_phy, act_vsd} !== 5'b01111) begin
            errors++; $display("[TB] FAIL areset_pre: got %b expected 01111", {sel, reset_img, act_phy, act_vsd});
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (reset_img !== 1'b0) begin errors++; $display("[TB] FAIL areset_reset_img: got %0b expected 0", reset_img); end
        checks++; if ({act_phy, act_vsd} !== 2'b00) begin errors++; $display("[TB] FAIL areset_act: got %b expected 00", {act_phy, act_vsd}); end
        checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL areset_sel: got %0d expected 0", sel); end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if ({sel, reset_img, act_phy, act_vsd} !== 5'b00000) begin
            errors++; $display("[TB] FAIL areset_after: got %b expected 00000", {sel, reset_img, act_phy, act_vsd});
        end
    endtask

    // Test sequence
    initial begin
        reset_n      = 1'b0;
        img_mounted  = 2'b00;
        img_nonempty = 2'b00;
        spi_sck      = 1'b0;
        spi_mosi     = 1'b0;
        spi_cs_n     = 1'b1;
        phy_miso     = 1'b0;
        vsd_miso     = 2'b00;
        #2;
        test_reset();
        test_phy_default();
        test_mount_slot1();
        test_back_to_back();
        test_empty_mount();
        test_sel_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
